sr_mem_rmw: RTL and testbench

- Parametrised read-modify-write shift-register memory: generalises the single-register shift/load datapath to a word array.
- Each write command fetches the stored word at addr, applies one of eight shift/rotate/load ops by a variable amount `shamt`, and writes the result back.
- Reads return the stored word with a fixed latency and a one-cycle DataValid pulse.
- Sits behind the serial-interface wrapper as its storage/datapath engine; commands are serialised through a ready handshake.

---
 rtl/sr_mem_rmw_pkg.sv | 44 ++++
 rtl/sr_mem_rmw_shift_unit.sv | 62 ++++++
 rtl/sr_mem_rmw.sv | 165 ++++++++++++++++
 tb/tb_sr_mem_rmw.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_mem_rmw_pkg.sv
// ============================================================================
// sr_mem_rmw_pkg : shared constants, op codes and FSM states for sr_mem_rmw
// Revision: 1.0
// ============================================================================
`default_nettype none

package sr_mem_rmw_pkg;

  localparam int DATAWIDTH = 8;
  localparam int ADDRWIDTH = 4;
  localparam int WRITE_LAT = 2;
  localparam int READ_LAT  = 1;

  // Counter holds (latency - 1) for whichever latency is larger.
  function automatic int cnt_width(input int wlat, input int rlat);
    int m;
    m = (wlat > rlat) ? wlat : rlat;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  localparam int CLOCKWIDTH = cnt_width(WRITE_LAT, READ_LAT);

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_LSR  = 3'd2,
    OP_LSL  = 3'd3,
    OP_RR   = 3'd4,
    OP_RL   = 3'd5,
    OP_ASR  = 3'd6,
    OP_ASL  = 3'd7
  } sr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RDWAIT = 3'd4
  } sr_state_e;

endpackage

`default_nettype wire

// File: rtl/sr_mem_rmw_shift_unit.sv
// ============================================================================
// sr_shift_unit : combinational shift/rotate/load datapath for one word
// Revision: 1.0
// ============================================================================
`default_nettype none

module sr_shift_unit
  import sr_mem_rmw_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int SHW       = $clog2(DATAWIDTH)
) (
  input  logic [DATAWIDTH-1:0] W,
  input  logic [DATAWIDTH-1:0] D,
  input  logic [2:0]           op,
  input  logic [SHW-1:0]       shamt,
  input  logic                 MSBIn,
  input  logic                 LSBIn,
  output logic [DATAWIDTH-1:0] result
);

  localparam logic [DATAWIDTH-1:0] C_ONES = '1;

  logic           w_over;
  logic [SHW-1:0] w_krot;
  logic [SHW:0]   w_kinv;

  // Only a non-power-of-2 width can see shamt >= DATAWIDTH.
  generate
    if ((2 ** SHW) == DATAWIDTH) begin : g_pow2
      assign w_over = 1'b0;
      assign w_krot = shamt;
    end else begin : g_npow2
      assign w_over = (shamt >= SHW'(DATAWIDTH));
      assign w_krot = SHW'(shamt % SHW'(DATAWIDTH));
    end
  endgenerate

  // Complementary rotate amount; equals DATAWIDTH when w_krot is 0, which shifts to zero.
  assign w_kinv = (SHW + 1)'(DATAWIDTH) - {1'b0, w_krot};

  always_comb begin
    result = W;
    case (sr_op_e'(op))
      OP_NOP:  result = W;
      OP_LOAD: result = D;
      OP_LSR:  result = w_over ? {DATAWIDTH{MSBIn}} :
                        ((W >> shamt) | (~(C_ONES >> shamt) & {DATAWIDTH{MSBIn}}));
      OP_LSL:  result = w_over ? {DATAWIDTH{LSBIn}} :
                        ((W << shamt) | (~(C_ONES << shamt) & {DATAWIDTH{LSBIn}}));
      OP_RR:   result = (W >> w_krot) | (W << w_kinv);
      OP_RL:   result = (W << w_krot) | (W >> w_kinv);
      OP_ASR:  result = w_over ? {DATAWIDTH{W[DATAWIDTH-1]}} :
                        ((W >> shamt) | (~(C_ONES >> shamt) & {DATAWIDTH{W[DATAWIDTH-1]}}));
      OP_ASL:  result = w_over ? '0 : (W << shamt);
      default: result = W;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sr_mem_rmw.sv
// ============================================================================
// sr_mem_rmw : read-modify-write shift-register memory engine
// Revision: 1.0
// ============================================================================
`default_nettype none

module sr_mem_rmw
  import sr_mem_rmw_pkg::*;
#(
  parameter int DATAWIDTH = sr_mem_rmw_pkg::DATAWIDTH,
  parameter int ADDRWIDTH = sr_mem_rmw_pkg::ADDRWIDTH,
  parameter int WRITE_LAT = sr_mem_rmw_pkg::WRITE_LAT,
  parameter int READ_LAT  = sr_mem_rmw_pkg::READ_LAT,
  parameter int SHW       = $clog2(DATAWIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATAWIDTH-1:0] D,
  input  logic [2:0]           S,
  input  logic [SHW-1:0]       shamt,
  input  logic                 MSBIn,
  input  logic                 LSBIn,
  input  logic [ADDRWIDTH-1:0] addr,
  input  logic                 wr_en,
  input  logic                 rd_en,
  output logic                 ready,
  output logic [DATAWIDTH-1:0] dataout,
  output logic                 DataValid
);

  localparam int CNTW  = cnt_width(WRITE_LAT, READ_LAT);
  localparam int DEPTH = 2 ** ADDRWIDTH;

  logic [DATAWIDTH-1:0] mem [DEPTH];

  sr_state_e            state_q,   state_d;
  logic [CNTW-1:0]      cnt_q,     cnt_d;
  sr_op_e               op_q,      op_d;
  logic [DATAWIDTH-1:0] d_q,       d_d;
  logic [DATAWIDTH-1:0] word_q,    word_d;
  logic [DATAWIDTH-1:0] dataout_q, dataout_d;
  logic [SHW-1:0]       shamt_q,   shamt_d;
  logic [ADDRWIDTH-1:0] addr_q,    addr_d;
  logic                 msb_q,     msb_d;
  logic                 lsb_q,     lsb_d;
  logic                 valid_q,   valid_d;

  logic [DATAWIDTH-1:0] w_result;
  logic                 w_mem_we;

  sr_shift_unit #(
    .DATAWIDTH (DATAWIDTH),
    .SHW       (SHW)
  ) u_shift (
    .W      (word_q),
    .D      (d_q),
    .op     (op_q),
    .shamt  (shamt_q),
    .MSBIn  (msb_q),
    .LSBIn  (lsb_q),
    .result (w_result)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    d_d       = d_q;
    word_d    = word_q;
    dataout_d = dataout_q;
    shamt_d   = shamt_q;
    addr_d    = addr_q;
    msb_d     = msb_q;
    lsb_d     = lsb_q;
    valid_d   = 1'b0;
    w_mem_we  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (wr_en || rd_en) begin
          op_d    = sr_op_e'(S);
          d_d     = D;
          shamt_d = shamt;
          msb_d   = MSBIn;
          lsb_d   = LSBIn;
          addr_d  = addr;
        end
        // Write wins when both requests arrive together.
        if (wr_en) begin
          state_d = ST_FETCH;
        end else if (rd_en) begin
          state_d = ST_RDWAIT;
          cnt_d   = CNTW'(READ_LAT - 1);
        end
      end
      ST_FETCH: begin
        word_d  = mem[addr_q];
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        w_mem_we = (op_q != OP_NOP);
        if (WRITE_LAT == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNTW'(WRITE_LAT - 1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_RDWAIT: begin
        if (cnt_q == '0) begin
          state_d   = ST_IDLE;
          valid_d   = 1'b1;
          dataout_d = mem[addr_q];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_NOP;
      d_q       <= '0;
      word_q    <= '0;
      dataout_q <= '0;
      shamt_q   <= '0;
      addr_q    <= '0;
      msb_q     <= 1'b0;
      lsb_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      d_q       <= d_d;
      word_q    <= word_d;
      dataout_q <= dataout_d;
      shamt_q   <= shamt_d;
      addr_q    <= addr_d;
      msb_q     <= msb_d;
      lsb_q     <= lsb_d;
      valid_q   <= valid_d;
    end
  end

  // Storage array carries no reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) mem[addr_q] <= w_result;
  end

  assign ready     = (state_q == ST_IDLE);
  assign dataout   = dataout_q;
  assign DataValid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_sr_mem_rmw.sv
// ============================================================================
// tb_sr_mem_rmw : scoreboard testbench for sr_mem_rmw and sr_shift_unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sr_mem_rmw;
  import sr_mem_rmw_pkg::*;

  localparam int N  = 8;
  localparam int AW = 4;
  localparam int WL = 2;
  localparam int RL = 1;

  logic         clk    = 1'b0;
  logic         reset  = 1'b0;
  logic [N-1:0] D      = '0;
  logic [2:0]   S      = '0;
  logic [2:0]   shamt  = '0;
  logic         MSBIn  = 1'b0;
  logic         LSBIn  = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic         wr_en  = 1'b0;
  logic         rd_en  = 1'b0;
  logic         ready;
  logic [N-1:0] dataout;
  logic         DataValid;

  logic [7:0] su_w = '0, su_d = '0, su_res;
  logic [2:0] su_op = '0, su_k = '0;
  logic       su_msb = 1'b0, su_lsb = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] model_mem [16];

  always #5 clk = ~clk;

  sr_mem_rmw #(
    .DATAWIDTH (N),
    .ADDRWIDTH (AW),
    .WRITE_LAT (WL),
    .READ_LAT  (RL),
    .SHW       (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .D         (D),
    .S         (S),
    .shamt     (shamt),
    .MSBIn     (MSBIn),
    .LSBIn     (LSBIn),
    .addr      (addr),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .ready     (ready),
    .dataout   (dataout),
    .DataValid (DataValid)
  );

  sr_shift_unit #(.DATAWIDTH(8), .SHW(3)) u_su (
    .W      (su_w),
    .D      (su_d),
    .op     (su_op),
    .shamt  (su_k),
    .MSBIn  (su_msb),
    .LSBIn  (su_lsb),
    .result (su_res)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Bit-by-bit reference model for the random phase.
  function automatic logic [7:0] model_op(input logic [7:0] w, input logic [2:0] op,
                                          input logic [7:0] d, input int k,
                                          input logic msb, input logic lsb);
    logic [7:0] r;
    r = w;
    for (int i = 0; i < 8; i++) begin
      case (op)
        3'd1: r[i] = d[i];
        3'd2: r[i] = (i + k < 8) ? w[i + k] : msb;
        3'd3: r[i] = (i >= k) ? w[i - k] : lsb;
        3'd4: r[i] = w[(i + k) % 8];
        3'd5: r[i] = w[(i - (k % 8) + 8) % 8];
        3'd6: r[i] = (i + k < 8) ? w[i + k] : w[7];
        3'd7: r[i] = (i >= k) ? w[i - k] : 1'b0;
        default: r[i] = w[i];
      endcase
    end
    return r;
  endfunction

  // Monitor: every DataValid pops one expected read.
  always @(negedge clk) begin
    logic [N-1:0] e;
    if (!reset && DataValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_datavalid: got dataout 0x%0h, expected no DataValid", dataout);
      end else begin
        e = exp_q.pop_front();
        check("read_data", 32'(dataout), 32'(e));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      errors++;
      $display("FAIL ready_timeout: got ready=%b, expected 1 within 100 cycles", ready);
    end
  endtask

  task automatic issue(input logic w, input logic r, input logic [2:0] op, input logic [3:0] a,
                       input logic [7:0] d, input logic [2:0] k, input logic msb, input logic lsb);
    wait_ready();
    wr_en = w; rd_en = r; S = op; addr = a; D = d; shamt = k; MSBIn = msb; LSBIn = lsb;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // Counts busy cycles after acceptance; optionally pokes a request while busy.
  task automatic busy(input int exp_low, input string name, input bit poke);
    int low = 0, val = 0, it = 0;
    while (it < 100) begin
      @(negedge clk);
      if (ready === 1'b1) break;
      low++;
      if (DataValid === 1'b1) val++;
      if (poke && it == 0) begin
        wr_en = 1'b1; rd_en = 1'b1; S = 3'd1; D = 8'h00; addr = 4'd15;
      end else if (poke && it == 1) begin
        wr_en = 1'b0; rd_en = 1'b0;
      end
      it++;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (it >= 100) begin
      errors++;
      $display("FAIL %s_timeout: got ready stuck low, expected release", name);
    end
    check({name, "_ready_low"}, 32'(low), 32'(exp_low));
    check({name, "_no_valid"}, 32'(val), 32'd0);
  endtask

  task automatic wr(input logic [2:0] op, input logic [3:0] a, input logic [7:0] d,
                    input logic [2:0] k, input logic msb, input logic lsb);
    issue(1'b1, 1'b0, op, a, d, k, msb, lsb);
    busy(2 + WL, "wr", 1'b0);
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] e);
    exp_q.push_back(e);
    issue(1'b0, 1'b1, 3'd0, a, 8'h00, 3'd0, 1'b0, 1'b0);
    busy(RL, "rd", 1'b0);
  endtask

  task automatic su_vec(input string name, input logic [7:0] w, input logic [2:0] op,
                        input logic [2:0] k, input logic [7:0] d, input logic msb,
                        input logic lsb, input logic [7:0] e);
    su_w = w; su_op = op; su_k = k; su_d = d; su_msb = msb; su_lsb = lsb;
    #1;
    check(name, 32'(su_res), 32'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200us");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] v, dd;
    logic [3:0] a;
    logic [2:0] op, k;
    logic       m1, l1;
    int         vcnt;

    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_valid", 32'(DataValid), 32'd0);
    check("rst_dataout", 32'(dataout), 32'd0);

    su_vec("su_lsr",  8'hA5, 3'd2, 3'd3, 8'h00, 1'b1, 1'b0, 8'hF4);
    su_vec("su_lsl0", 8'hF4, 3'd3, 3'd0, 8'h00, 1'b0, 1'b1, 8'hF4);
    su_vec("su_lsl2", 8'h0F, 3'd3, 3'd2, 8'h00, 1'b0, 1'b1, 8'h3F);
    su_vec("su_rl",   8'h3C, 3'd5, 3'd4, 8'h00, 1'b0, 1'b0, 8'hC3);
    su_vec("su_rr",   8'h81, 3'd4, 3'd1, 8'h00, 1'b0, 1'b0, 8'hC0);
    su_vec("su_rr0",  8'h81, 3'd4, 3'd0, 8'h00, 1'b0, 1'b0, 8'h81);
    su_vec("su_asr",  8'h90, 3'd6, 3'd2, 8'h00, 1'b0, 1'b0, 8'hE4);
    su_vec("su_asl",  8'h81, 3'd7, 3'd1, 8'h00, 1'b0, 1'b0, 8'h02);
    su_vec("su_load", 8'h00, 3'd1, 3'd5, 8'h5A, 1'b1, 1'b1, 8'h5A);

    wr(3'd1, 4'd3, 8'hA5, 3'd0, 1'b0, 1'b0); rd(4'd3, 8'hA5);
    wr(3'd2, 4'd3, 8'h00, 3'd3, 1'b1, 1'b0); rd(4'd3, 8'hF4);
    wr(3'd3, 4'd3, 8'h00, 3'd0, 1'b0, 1'b1); rd(4'd3, 8'hF4);
    wr(3'd0, 4'd3, 8'hFF, 3'd5, 1'b1, 1'b1); rd(4'd3, 8'hF4);
    wr(3'd1, 4'd1, 8'h3C, 3'd0, 1'b0, 1'b0); wr(3'd5, 4'd1, 8'h00, 3'd4, 1'b0, 1'b0); rd(4'd1, 8'hC3);
    wr(3'd1, 4'd2, 8'h90, 3'd0, 1'b0, 1'b0); wr(3'd6, 4'd2, 8'h00, 3'd2, 1'b0, 1'b0); rd(4'd2, 8'hE4);
    wr(3'd1, 4'd4, 8'h81, 3'd0, 1'b0, 1'b0); wr(3'd7, 4'd4, 8'h00, 3'd1, 1'b0, 1'b0); rd(4'd4, 8'h02);
    wr(3'd1, 4'd6, 8'h81, 3'd0, 1'b0, 1'b0); wr(3'd4, 4'd6, 8'h00, 3'd1, 1'b0, 1'b0); rd(4'd6, 8'hC0);

    // Simultaneous write+read at the top address, plus a request poked while busy.
    issue(1'b1, 1'b1, 3'd1, 4'd15, 8'h55, 3'd0, 1'b0, 1'b0);
    busy(2 + WL, "dual", 1'b1);
    rd(4'd15, 8'h55);

    // Reset during FETCH aborts the write.
    wr(3'd1, 4'd5, 8'h11, 3'd0, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 3'd1, 4'd5, 8'h77, 3'd0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    check("rst_fetch_ready", 32'(ready), 32'd1);
    rd(4'd5, 8'h11);

    // Reset during WAIT keeps the committed write.
    issue(1'b1, 1'b0, 3'd1, 4'd5, 8'h77, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    check("rst_wait_ready", 32'(ready), 32'd1);
    rd(4'd5, 8'h77);

    // Reset during RDWAIT suppresses DataValid.
    issue(1'b0, 1'b1, 3'd0, 4'd5, 8'h00, 3'd0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    check("rst_rd_ready", 32'(ready), 32'd1);
    vcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (DataValid === 1'b1) vcnt++;
    end
    check("rst_rd_no_valid", 32'(vcnt), 32'd0);

    for (int i = 0; i < 16; i++) begin
      v = 8'($urandom);
      wr(3'd1, 4'(i), v, 3'd0, 1'b0, 1'b0);
      model_mem[i] = v;
    end
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 4'($urandom_range(0, 15));
      k  = 3'($urandom_range(0, 7));
      dd = 8'($urandom);
      m1 = 1'($urandom);
      l1 = 1'($urandom);
      wr(op, a, dd, k, m1, l1);
      model_mem[a] = model_op(model_mem[a], op, dd, int'(k), m1, l1);
    end
    for (int i = 0; i < 16; i++) rd(4'(i), model_mem[i]);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
